// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Round-robin grant scheduler driving the one-hot select of a
//               CHANNELS-input data MUX. A grant is held for a multi-cycle
//               transfer and ends when the holder drops its request, signals
//               its last beat, or (optionally) reaches BURST_MAX cycles.
//               Priority rotates from the last granted channel, so no
//               requester starves.
// Options     : `define RR_BURST_LIMIT_EN  - caps each grant at BURST_MAX
//               cycles. A holder that is forced off re-enters arbitration
//               at the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int CHANNELS  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  input  logic                        last,
  output logic [CHANNELS-1:0]         gnt,
  output logic                        gnt_valid,
  output logic [$clog2(CHANNELS)-1:0] gnt_id
);

  localparam int IDW    = $clog2(CHANNELS);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  // The beat counter stops at BURST_MAX so that it can never wrap.
  localparam logic [BEAT_W-1:0] BEAT_SAT = BEAT_W'(BURST_MAX);
`ifdef RR_BURST_LIMIT_EN
  // Count value seen during the final allowed cycle of a grant.
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [CHANNELS-1:0]   gnt_q,      gnt_d;
  logic [IDW-1:0]        gnt_id_q,   gnt_id_d;
  logic [IDW-1:0]        ptr_q,      ptr_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]        w_cand;
  logic [IDW-1:0]        w_win_id;
  logic                  w_any_req;
  logic                  w_term;
  logic                  w_load;

  // Rotating search: start just after the last granted channel and take the
  // first requester. The current holder sits at the very end of the order,
  // so it only wins again when nobody else is asking.
  always_comb begin
    w_cand    = '0;
    w_win_id  = '0;
    w_any_req = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_cand = IDW'((int'(ptr_q) + k) % CHANNELS);
      if (!w_any_req && req[w_cand]) begin
        w_any_req = 1'b1;
        w_win_id  = w_cand;
      end
    end
  end

  // A grant ends when the holder withdraws, flags its last beat, or uses
  // up its burst allowance.
  always_comb begin
    w_term = !req[gnt_id_q] || last;
`ifdef RR_BURST_LIMIT_EN
    if (beat_cnt_q == BEAT_LAST) begin
      w_term = 1'b1;
    end
`endif
  end

  // Next-state and next-grant decision. A fresh grant is loaded in the same
  // way from IDLE and at the end of a grant, so back-to-back grants leave no
  // idle cycle between them.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    w_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (w_any_req) begin
          w_load = 1'b1;
        end
      end
      S_GRANT: begin
        if (!w_term) begin
          if (beat_cnt_q != BEAT_SAT) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (w_any_req) begin
          w_load = 1'b1;
        end else begin
          // gnt_id intentionally keeps the last holder's index while idle.
          state_d    = S_IDLE;
          gnt_d      = '0;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        gnt_d      = '0;
        beat_cnt_d = '0;
      end
    endcase

    if (w_load) begin
      state_d          = S_GRANT;
      gnt_d            = '0;
      gnt_d[w_win_id]  = 1'b1;
      gnt_id_d         = w_win_id;
      ptr_d            = w_win_id;
      beat_cnt_d       = '0;
    end
  end

  // State register. Reset points ptr at the top channel so that ch0 is
  // searched first afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= IDW'(CHANNELS - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;

endmodule
`default_nettype wire
